// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter: FSM states, grant
// identifiers and the round-robin pick rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    // On a tie the port that did not win last time goes next; a lone requester always wins.
    function automatic grant_e pick_grant(input logic fetch_req, input logic data_req,
                                          input grant_e last_grant);
        grant_e g;
        if (fetch_req && data_req) begin
            g = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (data_req) begin
            g = GNT_DATA;
        end else begin
            g = GNT_FETCH;
        end
        return g;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Wait counter for one memory access: cleared outside ACCESS, counts every
// ACCESS cycle, and flags the last cycle allowed before the access is aborted.
module arb_wait_timer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch and load/store, with registered handshake outputs and access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              err,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              timer_expired;
    logic              access_done;
    logic [DATA_W-1:0] resp_data;
    grant_e            pick;

    arb_wait_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ST_ACCESS),
        .enable  (state_q == ST_ACCESS),
        .expired (timer_expired)
    );

    assign pick        = pick_grant(if_req, d_req, last_grant_q);
    assign access_done = m_ready || timer_expired;
    // A timed-out access returns zero data; m_ready takes priority over the timeout.
    assign resp_data   = m_ready ? m_rdata : '0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_en_d       = 1'b0;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    grant_d = pick;
                    m_en_d  = 1'b1;
                    state_d = ST_ACCESS;
                    if (pick == GNT_DATA) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = if_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                m_en_d = 1'b1;
                if (access_done) begin
                    m_en_d  = 1'b0;
                    m_we_d  = 1'b0;
                    err_d   = !m_ready;
                    state_d = ST_RESP;
                    if (grant_q == GNT_FETCH) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = resp_data;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = resp_data;
                        end
                    end
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_FETCH;
            last_grant_q <= GNT_FETCH;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule
